regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 28 ++
 rtl/regfile_wb_arb.sv | 123 ++++++++++++
 tb/tb_regfile_wb_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile writeback arbiter: register geometry,
// controller state encoding and the port request bundle.
package regfile_pkg;

   localparam int NUM_REGS = 32;
   localparam int REG_AW   = 6;
   localparam int DATA_W   = 16;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   typedef struct packed {
      logic              word;
      logic [REG_AW-1:0] d;
      logic [DATA_W-1:0] rd;
   } wb_req_t;

   // Word requests cover an aligned register pair, so only the pair index counts.
   function automatic logic addr_hit(input logic word, input logic [REG_AW-1:0] d,
                                     input logic [REG_AW-1:0] ra);
      return word ? (d[REG_AW-1:1] == ra[REG_AW-1:1]) : (d == ra);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Port 0 is the ALU, port 1 the load unit;
// a tie goes to whichever port was not granted last.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Resets to the load unit so the ALU wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      last_grant <= 1'b1;
      else if (|grant) last_grant <= grant[1];
   end

endmodule

// File: rtl/regfile_wb_arb.sv
// Regfile writeback arbiter: optional post-reset clear sweep, then round-robin
// between the ALU and load-unit write ports with read-hazard stall generation.
module regfile_wb_arb
   import regfile_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter int CLEAR_WORDS    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_req,
   input  logic              alu_word,
   input  logic [REG_AW-1:0] alu_d,
   input  logic [DATA_W-1:0] alu_Rd,
   output logic              alu_ack,
   input  logic              ld_req,
   input  logic              ld_word,
   input  logic [REG_AW-1:0] ld_d,
   input  logic [DATA_W-1:0] ld_Rd,
   output logic              ld_ack,
   input  logic [REG_AW-1:0] rd_a,
   input  logic [REG_AW-1:0] rd_b,
   output logic              write,
   output logic              write_word,
   output logic [REG_AW-1:0] d,
   output logic [DATA_W-1:0] Rd,
   output logic              stall,
   output logic              busy,
   output logic              err
);

   localparam int IDX_W = REG_AW - 1;
   localparam int CW    = (CLEAR_WORDS > NUM_REGS) ? NUM_REGS : CLEAR_WORDS;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CW - 1);
   localparam state_e           RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

   state_e           state;
   logic [IDX_W-1:0] idx;
   logic             busy_q;
   logic             run_q;
   logic [1:0]       req;
   logic [1:0]       grant;
   logic             conflict;
   wb_req_t          alu_r, ld_r, sel;

   assign alu_r = '{word: alu_word, d: alu_d, rd: alu_Rd};
   assign ld_r  = '{word: ld_word,  d: ld_d,  rd: ld_Rd};

   // run_q only rises on the first RUN edge, so no ack can leak out during reset
   // or during the final clear write.
   assign req = {ld_req, alu_req} & {2{run_q}};

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (grant)
   );

   assign alu_ack = grant[0];
   assign ld_ack  = grant[1];
   assign sel     = grant[1] ? ld_r : alu_r;
   assign busy    = busy_q;

   // A request being acked this cycle is covered by the regfile bypass.
   always_comb begin
      conflict = 1'b0;
      if (alu_req && !grant[0] &&
          (addr_hit(alu_word, alu_d, rd_a) || addr_hit(alu_word, alu_d, rd_b)))
         conflict = 1'b1;
      if (ld_req && !grant[1] &&
          (addr_hit(ld_word, ld_d, rd_a) || addr_hit(ld_word, ld_d, rd_b)))
         conflict = 1'b1;
   end

   assign stall = busy_q | (run_q & conflict);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RST_STATE;
         idx        <= '0;
         busy_q     <= CLEAR_ON_RESET;
         run_q      <= 1'b0;
         write      <= 1'b0;
         write_word <= 1'b0;
         d          <= '0;
         Rd         <= '0;
         err        <= 1'b0;
      end else begin
         write <= 1'b0;
         err   <= 1'b0;
         case (state)
            ST_CLEAR: begin
               busy_q     <= 1'b1;
               run_q      <= 1'b0;
               write      <= 1'b1;
               write_word <= 1'b1;
               d          <= {idx, 1'b0};
               Rd         <= '0;
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  state <= ST_RUN;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
               run_q  <= 1'b1;
               if (|grant) begin
                  write      <= 1'b1;
                  write_word <= sel.word;
                  // Misaligned pair writes are realigned and flagged, not dropped.
                  d          <= sel.word ? {sel.d[REG_AW-1:1], 1'b0} : sel.d;
                  Rd         <= sel.rd;
                  err        <= sel.word & sel.d[0];
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: stimulus pushes expected writes into a
// scoreboard queue, a negedge monitor pops and compares every write it sees.
module tb_regfile_wb_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_req, alu_word, ld_req, ld_word;
   logic [5:0]  alu_d, ld_d, rd_a, rd_b;
   logic [15:0] alu_Rd, ld_Rd;
   logic        alu_ack, ld_ack, write, write_word, stall, busy, err;
   logic [5:0]  d;
   logic [15:0] Rd;

   typedef struct {
      logic        ww;
      logic [5:0]  d;
      logic [15:0] rd;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   regfile_wb_arb dut (
      .clk(clk), .reset(reset),
      .alu_req(alu_req), .alu_word(alu_word), .alu_d(alu_d), .alu_Rd(alu_Rd), .alu_ack(alu_ack),
      .ld_req(ld_req), .ld_word(ld_word), .ld_d(ld_d), .ld_Rd(ld_Rd), .ld_ack(ld_ack),
      .rd_a(rd_a), .rd_b(rd_b),
      .write(write), .write_word(write_word), .d(d), .Rd(Rd),
      .stall(stall), .busy(busy), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic ww, input logic [5:0] dd, input logic [15:0] r, input logic e);
      exp_t x;
      x.ww = ww; x.d = dd; x.rd = r; x.err = e;
      exp_q.push_back(x);
   endtask

   task automatic push_clear();
      for (int i = 0; i < 16; i++) push(1'b1, 6'(2 * i), 16'h0000, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (write) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write d=%0d Rd=%0h", d, Rd);
         end else begin
            e = exp_q.pop_front();
            chk("wr_word", {31'b0, write_word}, {31'b0, e.ww});
            chk("wr_d", {26'b0, d}, {26'b0, e.d});
            chk("wr_Rd", {16'b0, Rd}, {16'b0, e.rd});
            chk("wr_err", {31'b0, err}, {31'b0, e.err});
         end
      end
   end

   initial begin
      reset = 1'b0;
      alu_req = 0; alu_word = 0; alu_d = 0; alu_Rd = 0;
      ld_req = 0;  ld_word = 0;  ld_d = 0;  ld_Rd = 0;
      rd_a = 6'd50; rd_b = 6'd51;
      repeat (2) step();

      // Reset values
      chk("rst_write", write, 0);
      chk("rst_write_word", write_word, 0);
      chk("rst_d", d, 0);
      chk("rst_Rd", Rd, 0);
      chk("rst_alu_ack", alu_ack, 0);
      chk("rst_ld_ack", ld_ack, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 1);
      chk("rst_stall", stall, 1);

      // Clear sweep
      push_clear();
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("clr_busy", busy, 1);
         chk("clr_stall", stall, 1);
         chk("clr_write", write, 1);
      end
      step();
      chk("post_clr_busy", busy, 0);
      chk("post_clr_stall", stall, 0);
      chk("post_clr_write", write, 0);

      // Both ports continuously: ALU, ld, ALU, ld
      alu_req = 1; alu_d = 6'd10; alu_Rd = 16'h1111;
      ld_req  = 1; ld_d  = 6'd11; ld_Rd  = 16'h2222;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) push(1'b0, 6'd10, 16'h1111, 1'b0);
         else            push(1'b0, 6'd11, 16'h2222, 1'b0);
         @(negedge clk);
         chk("rr_alu_ack", alu_ack, (i % 2 == 0) ? 1 : 0);
         chk("rr_ld_ack", ld_ack, (i % 2 == 1) ? 1 : 0);
         step();
      end
      alu_req = 0; ld_req = 0;

      // ld waits on d=20 while ALU is granted
      alu_req = 1; alu_d = 6'd3;  alu_Rd = 16'h3333;
      ld_req  = 1; ld_d  = 6'd20; ld_Rd  = 16'h2020;
      rd_b = 6'd20;
      push(1'b0, 6'd3, 16'h3333, 1'b0);
      push(1'b0, 6'd20, 16'h2020, 1'b0);
      @(negedge clk);
      chk("haz_alu_ack", alu_ack, 1);
      chk("haz_ld_ack", ld_ack, 0);
      chk("haz_stall", stall, 1);
      rd_b = 6'd21;
      #1;
      chk("haz_nostall_21", stall, 0);
      rd_b = 6'd20;
      step();
      alu_req = 0;
      @(negedge clk);
      chk("haz_ld_ack2", ld_ack, 1);
      chk("haz_acked_nostall", stall, 0);
      step();
      ld_req = 0; rd_b = 6'd51;

      // ld alone
      ld_req = 1; ld_d = 6'd9; ld_Rd = 16'h0909;
      push(1'b0, 6'd9, 16'h0909, 1'b0);
      @(negedge clk);
      chk("ld_only_ack", ld_ack, 1);
      chk("ld_only_alu_ack", alu_ack, 0);
      step();
      ld_req = 0;

      // Word request pending matches its pair partner
      alu_req = 1; alu_d = 6'd1; alu_Rd = 16'h0001;
      ld_req = 1; ld_word = 1; ld_d = 6'd12; ld_Rd = 16'hC0C0;
      rd_a = 6'd13;
      push(1'b0, 6'd1, 16'h0001, 1'b0);
      push(1'b1, 6'd12, 16'hC0C0, 1'b0);
      @(negedge clk);
      chk("wpair_alu_ack", alu_ack, 1);
      chk("wpair_stall", stall, 1);
      step();
      alu_req = 0;
      @(negedge clk);
      chk("wpair_ld_ack", ld_ack, 1);
      step();
      ld_req = 0; ld_word = 0; rd_a = 6'd50;

      // ALU alone d=5
      alu_req = 1; alu_d = 6'd5; alu_Rd = 16'h00A5;
      push(1'b0, 6'd5, 16'h00A5, 1'b0);
      @(negedge clk);
      chk("alu_only_ack", alu_ack, 1);
      step();
      alu_req = 0;
      chk("alu_only_write", write, 1);
      step();
      chk("idle_write", write, 0);
      chk("idle_hold_d", d, 5);
      chk("idle_hold_Rd", Rd, 16'h00A5);
      chk("idle_alu_ack", alu_ack, 0);

      // Misaligned word
      alu_req = 1; alu_word = 1; alu_d = 6'd7; alu_Rd = 16'h7777;
      push(1'b1, 6'd6, 16'h7777, 1'b1);
      @(negedge clk);
      chk("mis_ack", alu_ack, 1);
      step();
      alu_req = 0; alu_word = 0;
      chk("mis_err", err, 1);
      step();
      chk("mis_err_clear", err, 0);

      // Reset mid-clear at idx 9
      reset = 1'b0;
      #1;
      exp_q.delete();
      push_clear();
      step();
      reset = 1'b1;
      repeat (9) step();
      chk("mid_clr_d16", d, 16);
      reset = 1'b0;
      #1;
      chk("mid_rst_write", write, 0);
      chk("mid_rst_d", d, 0);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_stall", stall, 1);
      exp_q.delete();
      push_clear();
      step();
      chk("mid_rst_hold", write, 0);
      reset = 1'b1;
      step();
      chk("restart_write", write, 1);
      chk("restart_d", d, 0);
      repeat (15) step();
      step();
      chk("restart_done_busy", busy, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
